// File: rtl/mem_wb_skid.sv
// MEM->WB pipeline register with a two-entry skid buffer (head + skid).
// Load data is sign/zero-extended at capture so WB sees a finished result.
module mem_wb_skid #(
  parameter int unsigned REGSIZE = 32,
  parameter int unsigned RDW     = 5
) (
  input  logic               clk,
  input  logic               r,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               reg_write_i,
  input  logic               mem_2_reg_i,
  input  logic [2:0]         funct3_i,
  input  logic [RDW-1:0]     rd_i,
  input  logic [REGSIZE-1:0] alu_result_i,
  input  logic [REGSIZE-1:0] read_data_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               reg_write_o,
  output logic [RDW-1:0]     rd_o,
  output logic [REGSIZE-1:0] wb_data_o,
  output logic [1:0]         occupancy_o
);

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

  logic               head_v_q, head_rw_q, skid_v_q, skid_rw_q;
  logic [RDW-1:0]     head_rd_q, skid_rd_q;
  logic [REGSIZE-1:0] head_data_q, skid_data_q;
  logic [1:0]         occ_q;

  logic               head_v_n, head_rw_n, skid_v_n, skid_rw_n;
  logic [RDW-1:0]     head_rd_n, skid_rd_n;
  logic [REGSIZE-1:0] head_data_n, skid_data_n;
  logic [1:0]         occ_n;

  logic [1:0]         off;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [REGSIZE-1:0] load_fmt;
  logic [REGSIZE-1:0] cap_data;
  logic               cap_rw;
  logic               accept, drain;

  // Load formatting: pick byte/halfword lane from the low address bits.
  always_comb begin
    off      = alu_result_i[1:0];
    byte_sel = 8'(read_data_i >> {off, 3'b000});
    half_sel = 16'(read_data_i >> {off[1], 4'b0000});
    case (funct3_e'(funct3_i))
      F3_LB:   load_fmt = {{(REGSIZE-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  load_fmt = {{(REGSIZE-8){1'b0}}, byte_sel};
      F3_LH:   load_fmt = {{(REGSIZE-16){half_sel[15]}}, half_sel};
      F3_LHU:  load_fmt = {{(REGSIZE-16){1'b0}}, half_sel};
      F3_LW:   load_fmt = read_data_i;
      default: load_fmt = read_data_i;
    endcase
    cap_data = mem_2_reg_i ? load_fmt : alu_result_i;
    cap_rw   = reg_write_i && (rd_i != '0);
  end

  assign in_ready    = !skid_v_q;
  assign out_valid   = head_v_q;
  assign reg_write_o = head_rw_q;
  assign rd_o        = head_rd_q;
  assign wb_data_o   = head_data_q;
  assign occupancy_o = occ_q;

  assign accept = in_valid && in_ready;
  assign drain  = head_v_q && out_ready;

  // head_rw is kept cleared whenever head goes invalid so reg_write_o needs no gating.
  always_comb begin
    head_v_n    = head_v_q;
    head_rw_n   = head_rw_q;
    head_rd_n   = head_rd_q;
    head_data_n = head_data_q;
    skid_v_n    = skid_v_q;
    skid_rw_n   = skid_rw_q;
    skid_rd_n   = skid_rd_q;
    skid_data_n = skid_data_q;
    if (flush) begin
      head_v_n  = 1'b0;
      head_rw_n = 1'b0;
      skid_v_n  = 1'b0;
      skid_rw_n = 1'b0;
    end else if (drain) begin
      if (skid_v_q) begin
        head_v_n    = 1'b1;
        head_rw_n   = skid_rw_q;
        head_rd_n   = skid_rd_q;
        head_data_n = skid_data_q;
        skid_v_n    = 1'b0;
        skid_rw_n   = 1'b0;
      end else if (accept) begin
        head_v_n    = 1'b1;
        head_rw_n   = cap_rw;
        head_rd_n   = rd_i;
        head_data_n = cap_data;
      end else begin
        head_v_n  = 1'b0;
        head_rw_n = 1'b0;
      end
    end else if (accept) begin
      if (!head_v_q) begin
        head_v_n    = 1'b1;
        head_rw_n   = cap_rw;
        head_rd_n   = rd_i;
        head_data_n = cap_data;
      end else begin
        skid_v_n    = 1'b1;
        skid_rw_n   = cap_rw;
        skid_rd_n   = rd_i;
        skid_data_n = cap_data;
      end
    end
    occ_n = {1'b0, head_v_n} + {1'b0, skid_v_n};
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      head_v_q    <= 1'b0;
      head_rw_q   <= 1'b0;
      head_rd_q   <= '0;
      head_data_q <= '0;
      skid_v_q    <= 1'b0;
      skid_rw_q   <= 1'b0;
      skid_rd_q   <= '0;
      skid_data_q <= '0;
      occ_q       <= '0;
    end else begin
      head_v_q    <= head_v_n;
      head_rw_q   <= head_rw_n;
      head_rd_q   <= head_rd_n;
      head_data_q <= head_data_n;
      skid_v_q    <= skid_v_n;
      skid_rw_q   <= skid_rw_n;
      skid_rd_q   <= skid_rd_n;
      skid_data_q <= skid_data_n;
      occ_q       <= occ_n;
    end
  end

endmodule

// File: doc/mem_wb_skid.md
MEM_WB_SKID -- requirements
Module: mem_wb_skid

Interface
REQ-001 SHALL have parameter REGSIZE, default 32, data width of result/load paths.
REQ-002 SHALL have parameter RDW, default 5, destination register index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port r  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-006 SHALL have ports in_valid input 1 / in_ready output 1, upstream (MEM) handshake.
REQ-007 SHALL have ports reg_write_i input 1, mem_2_reg_i input 1, funct3_i input 3, rd_i input RDW.
REQ-008 SHALL have ports alu_result_i input REGSIZE, read_data_i input REGSIZE (raw memory word).
REQ-009 SHALL have ports out_valid output 1 / out_ready input 1, downstream (WB) handshake.
REQ-010 SHALL have ports reg_write_o output 1, rd_o output RDW, wb_data_o output REGSIZE.
REQ-011 SHALL have port occupancy_o output 2, entries held (0..2).

Function
REQ-012 SHALL hold two entries: head (drives outputs) and skid; each = valid, reg_write, rd, wb_data.
REQ-013 SHALL transfer upstream when in_valid & in_ready at a rising edge; downstream when out_valid & out_ready.
REQ-014 SHALL drive in_ready = !skid.valid, from registered state only (no combinational path from out_ready).
REQ-015 SHALL drive out_valid = head.valid; outputs from head entry registers only.
REQ-016 SHALL compute wb_data at capture: mem_2_reg_i=0 -> alu_result_i; =1 -> formatted load.
REQ-017 SHALL format loads with off = alu_result_i[1:0]: LB(000)/LBU(100) select byte off, sign/zero extend.
REQ-018 SHALL for LH(001)/LHU(101) select halfword off[1], off[0] ignored, sign/zero extend.
REQ-019 SHALL for LW(010) and reserved codes 011/110/111 pass read_data_i unchanged.
REQ-020 SHALL force captured reg_write to 0 when rd_i == 0.
REQ-021 SHALL on accept with head empty, or head draining same cycle with skid empty, write head; latency 1 cycle in to out.
REQ-022 SHALL on accept while head is held (out_ready=0), write skid.
REQ-023 SHALL on drain with skid valid, move skid to head; simultaneous accept impossible (in_ready=0).
REQ-024 SHALL preserve order; no entry dropped or duplicated; no acceptance while 2 held.
REQ-025 SHALL on flush=1 clear both valid bits next edge, ignore same-cycle accept and drain; flush beats all.
REQ-026 SHALL drive occupancy_o = head.valid + skid.valid, registered.
REQ-027 SHALL keep data fields of invalid entries don't-care, but reg_write_o SHALL be 0 whenever out_valid=0.
REQ-028 SHALL sustain 1 transfer/cycle with out_ready held 1 continuously.

Reset
REQ-029 SHALL on r=0, immediately and independent of clk, clear head/skid valid, reg_write_o=0, rd_o=0, wb_data_o=0, occupancy_o=0, out_valid=0.
REQ-030 SHALL drive in_ready=1 during and after reset; an entry in flight when r falls is lost.
REQ-031 SHALL resume normal operation on first rising edge after r returns 1.

Verification
REQ-032 Stream: out_ready=1, 4 ALU results 0x11..0x14, rd=1..4 back-to-back -> out 1 cycle later each, occupancy 1, in_ready stays 1.
REQ-033 Load format: read_data=0x80FF7F01, LB off=3 -> 0xFFFFFF80; LBU off=1 -> 0x0000007F; LH off=2 -> 0xFFFF80FF; LHU off=3 -> 0x000080FF; LW -> 0x80FF7F01.
REQ-034 Backpressure: out_ready=0, send A,B -> occupancy 2, in_ready 0, C held upstream; out_ready=1 -> A,B,C in order, occupancy back to 1.
REQ-035 Flush: occupancy 2, flush=1 with in_valid=1 and out_ready=1 -> next cycle occupancy 0, out_valid 0, in_ready 1, input not captured.
REQ-036 rd=0: reg_write_i=1, rd_i=0, alu=0xDEAD -> out_valid 1, reg_write_o 0, wb_data_o 0xDEAD.
REQ-037 Async reset: occupancy 2, drop r mid-cycle -> outputs zero before next edge; release -> in_ready 1, first new input out after 1 cycle.
